// File: rtl/robo_wall_follower_param.sv
// Wall-following cleaning-robot controller with stuck detection, removal
// timeout/skip, run/pause and saturating telemetry counters.
module robo_wall_follower_param #(
    parameter int unsigned ROT_LIMIT  = 8,
    parameter int unsigned REMOVE_MAX = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             follow_right,
    input  logic             head,
    input  logic             left,
    input  logic             right,
    input  logic             under,
    input  logic             barrier,
    output logic             avancar,
    output logic             girar,
    output logic             remover,
    output logic             stuck,
    output logic             remove_fail,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] removed_count
);

    localparam int unsigned ROT_W = $clog2(ROT_LIMIT);
    localparam int unsigned RM_W  = $clog2(REMOVE_MAX);
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_LIMIT - 1);
    localparam logic [RM_W-1:0]  RM_LAST  = RM_W'(REMOVE_MAX - 1);

    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_SEEK    = 3'd1,
        S_ROTATE  = 3'd2,
        S_FOLLOW  = 3'd3,
        S_REMOVE  = 3'd4,
        S_STANDBY = 3'd5,
        S_STUCK   = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_mode;
    logic              r_skip;
    logic [ROT_W-1:0]  r_rot_cnt;
    logic [RM_W-1:0]   r_rm_cnt;
    logic [CNT_W-1:0]  r_step_cnt;
    logic [CNT_W-1:0]  r_removed_cnt;
    logic              r_avancar;
    logic              r_girar;
    logic              r_remover;
    logic              r_stuck;
    logic              r_remove_fail;

    logic              w_side;
    logic              w_can_remove;
    logic              w_rm_done;
    logic              w_rm_fail;

    // In INIT the side select has not been latched yet, so use the live input.
    assign w_side = (r_state == S_INIT) ? (follow_right ? right : left)
                                        : (r_mode ? right : left);

    assign w_can_remove = barrier && !r_skip &&
                          ((r_state == S_INIT) || (r_state == S_SEEK) ||
                           (r_state == S_ROTATE) || (r_state == S_FOLLOW));

    always_comb begin
        w_next    = r_state;
        w_rm_done = 1'b0;
        w_rm_fail = 1'b0;
        if (under || (r_state == S_STANDBY)) begin
            w_next = S_STANDBY;
        end else if (!enable) begin
            w_next = S_INIT;
        end else if (w_can_remove) begin
            w_next = S_REMOVE;
        end else begin
            case (r_state)
                S_INIT, S_SEEK: begin
                    if (!head && w_side)
                        w_next = S_FOLLOW;
                    else if (head)
                        w_next = S_ROTATE;
                    else
                        w_next = S_SEEK;
                end
                S_ROTATE: begin
                    if (!head && w_side)
                        w_next = S_FOLLOW;
                    else if (r_rot_cnt == ROT_LAST)
                        w_next = S_STUCK;
                end
                S_FOLLOW: begin
                    if (head)
                        w_next = S_ROTATE;
                    else if (!w_side)
                        w_next = S_SEEK;
                end
                S_REMOVE: begin
                    if (!barrier) begin
                        w_rm_done = 1'b1;
                        w_next    = w_side ? S_FOLLOW : S_SEEK;
                    end else if (r_rm_cnt == RM_LAST) begin
                        w_rm_fail = 1'b1;
                        w_next    = S_ROTATE;
                    end
                end
                S_STUCK:   w_next = S_STUCK;
                default:   w_next = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_INIT;
            r_mode        <= 1'b0;
            r_skip        <= 1'b0;
            r_rot_cnt     <= '0;
            r_rm_cnt      <= '0;
            r_step_cnt    <= '0;
            r_removed_cnt <= '0;
            r_avancar     <= 1'b0;
            r_girar       <= 1'b0;
            r_remover     <= 1'b0;
            r_stuck       <= 1'b0;
            r_remove_fail <= 1'b0;
        end else begin
            r_state <= w_next;

            // Outputs are decoded from the next state so they track r_state exactly.
            r_avancar     <= (w_next == S_SEEK) || (w_next == S_FOLLOW);
            r_girar       <= (w_next == S_ROTATE);
            r_remover     <= (w_next == S_REMOVE);
            r_stuck       <= (w_next == S_STUCK);
            r_remove_fail <= w_rm_fail;

            if ((r_state == S_INIT) && (w_next != S_INIT))
                r_mode <= follow_right;

            if (w_rm_fail)
                r_skip <= 1'b1;
            else if (!barrier)
                r_skip <= 1'b0;

            r_rot_cnt <= ((r_state == S_ROTATE) && (w_next == S_ROTATE))
                         ? r_rot_cnt + 1'b1 : '0;
            r_rm_cnt  <= ((r_state == S_REMOVE) && (w_next == S_REMOVE))
                         ? r_rm_cnt + 1'b1 : '0;

            if (((r_state == S_SEEK) || (r_state == S_FOLLOW)) && (r_step_cnt != '1))
                r_step_cnt <= r_step_cnt + 1'b1;

            if (w_rm_done && (r_removed_cnt != '1))
                r_removed_cnt <= r_removed_cnt + 1'b1;
        end
    end

    assign avancar       = r_avancar;
    assign girar         = r_girar;
    assign remover       = r_remover;
    assign stuck         = r_stuck;
    assign remove_fail   = r_remove_fail;
    assign state         = r_state;
    assign step_count    = r_step_cnt;
    assign removed_count = r_removed_cnt;

endmodule

// File: tb/tb_robo_wall_follower_param.sv
// Directed self-checking bench for robo_wall_follower_param (default build
// plus a CNT_W=4 build sharing the same stimulus).
module tb_robo_wall_follower_param;

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_SEEK    = 3'd1;
    localparam logic [2:0] ST_ROTATE  = 3'd2;
    localparam logic [2:0] ST_FOLLOW  = 3'd3;
    localparam logic [2:0] ST_REMOVE  = 3'd4;
    localparam logic [2:0] ST_STANDBY = 3'd5;
    localparam logic [2:0] ST_STUCK   = 3'd6;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable, follow_right, head, left, right, under, barrier;
    logic        avancar, girar, remover, stuck, remove_fail;
    logic [2:0]  state;
    logic [15:0] step_count, removed_count;
    logic        t4_avancar, t4_girar, t4_remover, t4_stuck, t4_remove_fail;
    logic [2:0]  t4_state;
    logic [3:0]  t4_step_count, t4_removed_count;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    robo_wall_follower_param #(.ROT_LIMIT(8), .REMOVE_MAX(16), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .follow_right(follow_right),
        .head(head), .left(left), .right(right), .under(under), .barrier(barrier),
        .avancar(avancar), .girar(girar), .remover(remover), .stuck(stuck),
        .remove_fail(remove_fail), .state(state), .step_count(step_count),
        .removed_count(removed_count)
    );

    robo_wall_follower_param #(.ROT_LIMIT(8), .REMOVE_MAX(16), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .enable(enable), .follow_right(follow_right),
        .head(head), .left(left), .right(right), .under(under), .barrier(barrier),
        .avancar(t4_avancar), .girar(t4_girar), .remover(t4_remover), .stuck(t4_stuck),
        .remove_fail(t4_remove_fail), .state(t4_state), .step_count(t4_step_count),
        .removed_count(t4_removed_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        enable = 1'b0; follow_right = 1'b0; head = 1'b0;
        left = 1'b0; right = 1'b0; under = 1'b0; barrier = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable = 1'b1; head = 1'b1; barrier = 1'b1;
        tick();
        tick();
        checks++; if (state !== ST_INIT) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state, ST_INIT); end
        checks++; if ({avancar, girar, remover, stuck, remove_fail} !== 5'b0) begin errors++; $display("FAIL reset_outputs got=%b exp=00000", {avancar, girar, remover, stuck, remove_fail}); end
        checks++; if (step_count !== 16'd0 || removed_count !== 16'd0) begin errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", step_count, removed_count); end
    endtask

    task automatic test_follow_left();
        do_reset();
        enable = 1'b1; follow_right = 1'b0; left = 1'b1; head = 1'b0;
        tick();
        checks++; if (state !== ST_FOLLOW || avancar !== 1'b1) begin errors++; $display("FAIL follow_entry got=%0d/%b exp=%0d/1", state, avancar, ST_FOLLOW); end
        checks++; if (step_count !== 16'd0) begin errors++; $display("FAIL follow_step0 got=%0d exp=0", step_count); end
        repeat (4) tick();
        checks++; if (step_count !== 16'd4) begin errors++; $display("FAIL follow_step4 got=%0d exp=4", step_count); end
        enable = 1'b0;
        tick();
        checks++; if (state !== ST_INIT || avancar !== 1'b0) begin errors++; $display("FAIL pause_init got=%0d/%b exp=%0d/0", state, avancar, ST_INIT); end
        tick();
        checks++; if (step_count !== 16'd5) begin errors++; $display("FAIL pause_step_hold got=%0d exp=5", step_count); end
    endtask

    task automatic test_stuck();
        enable = 1'b1; follow_right = 1'b1; right = 1'b0; left = 1'b1; head = 1'b1;
        tick();
        checks++; if (state !== ST_ROTATE || girar !== 1'b1) begin errors++; $display("FAIL rotate_entry got=%0d/%b exp=%0d/1", state, girar, ST_ROTATE); end
        repeat (7) tick();
        checks++; if (state !== ST_ROTATE || girar !== 1'b1) begin errors++; $display("FAIL rotate_8th got=%0d/%b exp=%0d/1", state, girar, ST_ROTATE); end
        tick();
        checks++; if (state !== ST_STUCK || stuck !== 1'b1 || girar !== 1'b0) begin errors++; $display("FAIL stuck_entry got=%0d/%b/%b exp=%0d/1/0", state, stuck, girar, ST_STUCK); end
        head = 1'b0; left = 1'b1; follow_right = 1'b0;
        repeat (2) tick();
        checks++; if (state !== ST_STUCK) begin errors++; $display("FAIL stuck_hold got=%0d exp=%0d", state, ST_STUCK); end
        checks++; if (step_count !== 16'd5) begin errors++; $display("FAIL stuck_step_persist got=%0d exp=5", step_count); end
        enable = 1'b0;
        tick();
        checks++; if (state !== ST_INIT || stuck !== 1'b0) begin errors++; $display("FAIL stuck_exit got=%0d/%b exp=%0d/0", state, stuck, ST_INIT); end
    endtask

    task automatic test_remove();
        int n;
        do_reset();
        enable = 1'b1; left = 1'b1;
        tick();
        barrier = 1'b1;
        n = 0;
        repeat (3) begin
            tick();
            if (remover === 1'b1 && state === ST_REMOVE) n++;
        end
        barrier = 1'b0;
        tick();
        checks++; if (n !== 3) begin errors++; $display("FAIL remove_cycles got=%0d exp=3", n); end
        checks++; if (state !== ST_FOLLOW || remover !== 1'b0) begin errors++; $display("FAIL remove_return got=%0d/%b exp=%0d/0", state, remover, ST_FOLLOW); end
        checks++; if (removed_count !== 16'd1) begin errors++; $display("FAIL removed_count got=%0d exp=1", removed_count); end
    endtask

    task automatic test_remove_timeout();
        int rm, fails, fail_at;
        do_reset();
        enable = 1'b1; left = 1'b1;
        tick();
        barrier = 1'b1; left = 1'b0;
        rm = 0; fails = 0; fail_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (remover === 1'b1) rm++;
            if (remove_fail === 1'b1) begin fails++; fail_at = i; end
        end
        checks++; if (rm !== 16) begin errors++; $display("FAIL timeout_remove_cycles got=%0d exp=16", rm); end
        checks++; if (fails !== 1 || fail_at !== 17) begin errors++; $display("FAIL timeout_pulse got=%0d@%0d exp=1@17", fails, fail_at); end
        checks++; if (state !== ST_ROTATE) begin errors++; $display("FAIL timeout_skip_rotate got=%0d exp=%0d", state, ST_ROTATE); end
        barrier = 1'b0;
        tick();
        checks++; if (state !== ST_ROTATE) begin errors++; $display("FAIL skip_clear_rotate got=%0d exp=%0d", state, ST_ROTATE); end
        barrier = 1'b1;
        tick();
        checks++; if (state !== ST_REMOVE) begin errors++; $display("FAIL skip_cleared_reenter got=%0d exp=%0d", state, ST_REMOVE); end
        checks++; if (removed_count !== 16'd0) begin errors++; $display("FAIL timeout_removed_count got=%0d exp=0", removed_count); end
    endtask

    task automatic test_standby();
        do_reset();
        enable = 1'b1; left = 1'b1;
        tick();
        under = 1'b1; barrier = 1'b1; enable = 1'b0;
        tick();
        checks++; if (state !== ST_STANDBY) begin errors++; $display("FAIL standby_entry got=%0d exp=%0d", state, ST_STANDBY); end
        checks++; if ({avancar, girar, remover, stuck, remove_fail} !== 5'b0) begin errors++; $display("FAIL standby_outputs got=%b exp=00000", {avancar, girar, remover, stuck, remove_fail}); end
        under = 1'b0; barrier = 1'b0; enable = 1'b1;
        repeat (4) tick();
        checks++; if (state !== ST_STANDBY || avancar !== 1'b0) begin errors++; $display("FAIL standby_hold got=%0d/%b exp=%0d/0", state, avancar, ST_STANDBY); end
        do_reset();
        enable = 1'b1; left = 1'b1;
        tick();
        barrier = 1'b1;
        tick();
        under = 1'b1;
        tick();
        checks++; if (state !== ST_STANDBY || remover !== 1'b0) begin errors++; $display("FAIL standby_from_remove got=%0d/%b exp=%0d/0", state, remover, ST_STANDBY); end
    endtask

    task automatic test_saturate_and_async_reset();
        do_reset();
        enable = 1'b1;
        tick();
        checks++; if (state !== ST_SEEK || avancar !== 1'b1) begin errors++; $display("FAIL seek_entry got=%0d/%b exp=%0d/1", state, avancar, ST_SEEK); end
        repeat (15) tick();
        checks++; if (t4_step_count !== 4'd15 || step_count !== 16'd15) begin errors++; $display("FAIL sat_reach got=%0d/%0d exp=15/15", t4_step_count, step_count); end
        tick();
        checks++; if (t4_step_count !== 4'd15 || step_count !== 16'd16) begin errors++; $display("FAIL sat_nowrap got=%0d/%0d exp=15/16", t4_step_count, step_count); end
        repeat (4) tick();
        checks++; if (t4_step_count !== 4'd15 || step_count !== 16'd20) begin errors++; $display("FAIL sat_hold got=%0d/%0d exp=15/20", t4_step_count, step_count); end
        left = 1'b1;
        tick();
        checks++; if (state !== ST_FOLLOW || avancar !== 1'b1) begin errors++; $display("FAIL prereset_follow got=%0d/%b exp=%0d/1", state, avancar, ST_FOLLOW); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (avancar !== 1'b0 || t4_avancar !== 1'b0) begin errors++; $display("FAIL async_reset_avancar got=%b/%b exp=0/0", avancar, t4_avancar); end
        checks++; if (state !== ST_INIT || step_count !== 16'd0 || t4_step_count !== 4'd0) begin errors++; $display("FAIL async_reset_state got=%0d/%0d/%0d exp=0/0/0", state, step_count, t4_step_count); end
        #10;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0; follow_right = 1'b0; head = 1'b0;
        left = 1'b0; right = 1'b0; under = 1'b0; barrier = 1'b0;
        #2;
        test_reset();
        test_follow_left();
        test_stuck();
        test_remove();
        test_remove_timeout();
        test_standby();
        test_saturate_and_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/robo_wall_follower_param.md
Name: robo_wall_follower_param

Overview:
- Parametrised successor to the wall-following cleaning-robot controller.
- Drives a robot along a left or right wall, selected at run time.
- Removes debris when the barrier sensor fires, and halts permanently on a floor hazard (under).
- Adds behaviour the previous generation lacked: rotation-stuck detection, removal timeout with skip, enable/pause, and saturating step/removal counters for telemetry.

Parameters:
ROT_LIMIT, 8, max consecutive ROTATE cycles before declaring STUCK (>=2)
REMOVE_MAX, 16, max consecutive REMOVE cycles before giving up on an obstacle (>=2)
CNT_W, 16, width of step_count and removed_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  run/pause; 0 forces INIT (except from STANDBY)
follow_right  in  1  wall side select, latched only on INIT exit (0=left, 1=right)
head  in  1  obstacle/wall ahead
left  in  1  wall on left
right  in  1  wall on right
under  in  1  floor hazard under robot
barrier  in  1  removable debris ahead
avancar  out  1  move forward
girar  out  1  rotate in place
remover  out  1  activate remover
stuck  out  1  high while in STUCK
remove_fail  out  1  one-cycle pulse on removal timeout
state  out  3  current state encoding
step_count  out  CNT_W  saturating count of cycles spent in SEEK/FOLLOW
removed_count  out  CNT_W  saturating count of successful removals

Behaviour:
- Clocking: single clock domain; all registers update on the rising edge of clock.
- Reset (reset=0, asynchronous):
  - state=INIT; all outputs 0; counters 0; mode=0; skip=0; rot_cnt=rm_cnt=0.
- State encoding: INIT=0, SEEK=1, ROTATE=2, FOLLOW=3, REMOVE=4, STANDBY=5, STUCK=6.
- Outputs are a Moore decode of the registered state, so there is 1 cycle latency from sensors to outputs:
  - avancar=1 in SEEK, FOLLOW
  - girar=1 in ROTATE
  - remover=1 in REMOVE
  - stuck=1 in STUCK
  - all others 0
- side = mode ? right : left, where mode is latched from follow_right on the INIT->non-INIT transition.
- Next-state priority, highest first:
  1. under=1 -> STANDBY (from any state).
  2. enable=0 -> INIT (any state except STANDBY).
  3. barrier=1 and skip=0 -> REMOVE (from SEEK, ROTATE, FOLLOW, INIT).
  4. Per-state rules below.
- INIT:
  - head=0 & side=1 -> FOLLOW
  - head=1 -> ROTATE
  - else -> SEEK
  - side is evaluated with the new follow_right value in this cycle.
- SEEK:
  - head=0 & side=1 -> FOLLOW
  - head=1 -> ROTATE
  - else stay.
- ROTATE:
  - head=0 & side=1 -> FOLLOW; rot_cnt cleared.
  - else rot_cnt increments each cycle; when rot_cnt==ROT_LIMIT-1 -> STUCK.
  - rot_cnt is cleared on any exit from ROTATE.
- FOLLOW:
  - head=1 -> ROTATE
  - side=0 -> SEEK
  - else stay.
- REMOVE (rm_cnt counts cycles in REMOVE, cleared on exit):
  - barrier=0 -> removed_count+1 (saturate at all-ones); then FOLLOW if side=1, else SEEK.
  - barrier=1 & rm_cnt==REMOVE_MAX-1 -> ROTATE; remove_fail pulses 1 cycle; skip=1.
  - else stay.
- skip: cleared on any cycle with barrier=0. While skip=1, priority rule 3 is ignored.
- STUCK: stays until enable=0 (-> INIT) or under=1 (-> STANDBY).
- STANDBY: terminal; only reset exits it.
- step_count: +1 on each cycle the registered state is SEEK or FOLLOW; saturates at 2^CNT_W-1, no wrap.
- Counters persist across INIT/pause and clear only on reset.
- Reset mid-operation: all outputs drop to 0 immediately (asynchronous).

Test Plan:
- Reset, enable=1, follow_right=0, left=1, head=0 -> INIT->FOLLOW; avancar=1 from 2nd edge; step_count increments each cycle.
- follow_right=1, right=0, head=1 held 8 cycles (ROT_LIMIT=8) -> ROTATE 8 cycles, then STUCK; stuck=1, girar=0; then enable=0 -> state=INIT.
- In FOLLOW, barrier=1 for 3 cycles then 0 -> remover=1 for 3 cycles; removed_count=1; returns to FOLLOW.
- barrier held 20 cycles (REMOVE_MAX=16) -> remove_fail single pulse after 16 REMOVE cycles; ROTATE entered and not re-entering REMOVE until barrier drops.
- under=1 in any state, including simultaneous with barrier=1 and enable=0 -> STANDBY; all outputs 0; remains in STANDBY after under=0 until reset.
- CNT_W=4, 20 cycles in SEEK -> step_count saturates at 15; assert reset=0 mid-FOLLOW -> avancar falls without waiting for a clock edge.
